// File: rtl/fetch_responder.sv
// Fetch responder: owns the program counter, issues instruction-memory reads
// with a timeout, and latches returned bytes into MDR and the instruction register.
module fetch_responder #(
  parameter int                 ADDR_W   = 16,
  parameter int                 TIMEOUT  = 15,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic              pc_inc,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic              ir_load,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  input  logic              mem_rd_valid,
  output logic [7:0]        mdr,
  output logic [7:0]        dec_in,
  output logic              fetch_done,
  output logic              busy,
  output logic              bus_err,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state_q, state_d;
  logic              pending_q, pending_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        mdr_q, mdr_d;
  logic              done_d;
  logic              err_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    mdr_d     = mdr_q;
    done_d    = 1'b0;
    err_d     = bus_err;
    unique case (state_q)
      IDLE: begin
        if (fetch_req || pending_q) begin
          state_d   = ISSUE;
          pending_d = 1'b0;
          addr_d    = pc;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
        if (fetch_req) pending_d = 1'b1;
      end
      WAIT: begin
        if (mem_rd_valid) begin
          // Data on the final counted cycle still wins over the timeout.
          mdr_d  = mem_rd_data;
          done_d = 1'b1;
          if (pending_q || fetch_req) begin
            state_d   = ISSUE;
            pending_d = 1'b0;
            addr_d    = pc;
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_q == 8'(TIMEOUT)) begin
          mdr_d   = 8'h00;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
          if (fetch_req) pending_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (fetch_req) pending_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments make every register see pre-edge values, so
  // an ir_load coinciding with an MDR write copies the old MDR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      mdr_q      <= 8'h00;
      dec_in     <= 8'h00;
      fetch_done <= 1'b0;
      bus_err    <= 1'b0;
      pc         <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      mdr_q      <= mdr_d;
      fetch_done <= done_d;
      bus_err    <= err_d;
      if (ir_load) dec_in <= mdr_q;
      if (pc_load)     pc <= pc_load_val;
      else if (pc_inc) pc <= pc + ADDR_W'(1);
    end
  end

  assign mem_rd_en = (state_q == ISSUE);
  assign mem_addr  = addr_q;
  assign mdr       = mdr_q;
  assign busy      = (state_q != IDLE) || pending_q;

endmodule

// File: tb/tb_fetch_responder.sv
// Directed bench for fetch_responder: a cycle-level reference model checked every
// cycle, plus literal expectations taken straight from the behaviour rules.
module tb_fetch_responder;
  localparam int T = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0, pc_inc = 1'b0, pc_load = 1'b0, ir_load = 1'b0;
  logic [15:0] pc_load_val = '0;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rd_data = '0;
  logic        mem_rd_valid = 1'b0;
  logic [7:0]  mdr, dec_in;
  logic        fetch_done, busy, bus_err;
  logic [15:0] pc;

  int errors = 0;
  int checks = 0;
  int rd_pulses = 0;

  fetch_responder #(.ADDR_W(16), .TIMEOUT(T), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc_inc(pc_inc),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .ir_load(ir_load),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid), .mdr(mdr), .dec_in(dec_in),
    .fetch_done(fetch_done), .busy(busy), .bus_err(bus_err), .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (mem_rd_en) rd_pulses++;
  endtask

  // Reference model. age: -1 no read; 0 issue cycle; k>=1 means k-1 cycles spent waiting.
  int          age = -1;
  logic        pend_m = 1'b0, done_m = 1'b0, err_m = 1'b0;
  logic [15:0] pc_m = '0, addr_m = '0;
  logic [7:0]  mdr_m = '0, dec_m = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      age = -1; pend_m = 1'b0; done_m = 1'b0; err_m = 1'b0;
      pc_m = '0; addr_m = '0; mdr_m = '0; dec_m = '0;
    end else begin
      if (ir_load) dec_m = mdr_m;
      done_m = 1'b0;
      if (age < 0) begin
        if (fetch_req || pend_m) begin age = 0; addr_m = pc_m; pend_m = 1'b0; end
      end else if (age == 0) begin
        age = 1;
        if (fetch_req) pend_m = 1'b1;
      end else if (mem_rd_valid) begin
        mdr_m = mem_rd_data; done_m = 1'b1;
        if (pend_m || fetch_req) begin age = 0; addr_m = pc_m; pend_m = 1'b0; end
        else age = -1;
      end else if (age == T + 1) begin
        mdr_m = 8'h00; err_m = 1'b1; done_m = 1'b1; age = -1;
        if (fetch_req) pend_m = 1'b1;
      end else begin
        age++;
        if (fetch_req) pend_m = 1'b1;
      end
      if (pc_load) pc_m = pc_load_val;
      else if (pc_inc) pc_m = pc_m + 16'd1;
    end
    #1;
    if (rst_n) begin
      check("m_rd_en", mem_rd_en, age == 0);
      if (age >= 0) check("m_addr", mem_addr, addr_m);
      check("m_busy", busy, (age >= 0) || pend_m);
      check("m_done", fetch_done, done_m);
      check("m_err", bus_err, err_m);
      check("m_mdr", mdr, mdr_m);
      check("m_dec", dec_in, dec_m);
      check("m_pc", pc, pc_m);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    cycle(); cycle();
    check("rst_pc", pc, 16'h0000);
    check("rst_busy", busy, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_mdr", mdr, 8'h00);
    check("rst_err", bus_err, 0);
    rst_n = 1'b1;
    cycle();

    // Zero-wait fetch from 0x0010; valid in the issue cycle must be ignored
    pc_load = 1'b1; pc_load_val = 16'h0010;
    cycle(); pc_load = 1'b0;
    fetch_req = 1'b1;
    cycle(); fetch_req = 1'b0;
    check("zw_rd_en", mem_rd_en, 1);
    check("zw_addr", mem_addr, 16'h0010);
    mem_rd_valid = 1'b1; mem_rd_data = 8'hEE;
    cycle(); mem_rd_data = 8'h61;
    cycle(); mem_rd_valid = 1'b0;
    check("zw_done", fetch_done, 1);
    check("zw_mdr", mdr, 8'h61);
    ir_load = 1'b1;
    cycle(); ir_load = 1'b0;
    check("zw_dec", dec_in, 8'h61);
    check("zw_done_pulse", fetch_done, 0);

    // PC control: load beats increment; increment wraps
    pc_inc = 1'b1; pc_load = 1'b1; pc_load_val = 16'h1234;
    cycle(); pc_inc = 1'b0; pc_load = 1'b0;
    check("pc_prio", pc, 16'h1234);
    pc_load = 1'b1; pc_load_val = 16'hFFFF;
    cycle(); pc_load = 1'b0; pc_inc = 1'b1;
    cycle(); pc_inc = 1'b0;
    check("pc_wrap", pc, 16'h0000);

    // Pending request, third request dropped
    rd_pulses = 0;
    fetch_req = 1'b1;
    cycle(); fetch_req = 1'b0; pc_inc = 1'b1;
    cycle(); pc_inc = 1'b0; fetch_req = 1'b1;
    cycle();
    check("pend_busy", busy, 1);
    cycle(); fetch_req = 1'b0; mem_rd_valid = 1'b1; mem_rd_data = 8'h5A;
    cycle(); mem_rd_valid = 1'b0;
    check("pend_rd_en2", mem_rd_en, 1);
    check("pend_addr2", mem_addr, 16'h0001);
    check("pend_mdr1", mdr, 8'h5A);
    cycle(); mem_rd_valid = 1'b1; mem_rd_data = 8'hA5;
    cycle(); mem_rd_valid = 1'b0;
    repeat (4) cycle();
    check("pend_pulses", rd_pulses, 2);
    check("pend_idle", busy, 0);
    check("pend_mdr2", mdr, 8'hA5);

    // Timeout: memory never answers
    fetch_req = 1'b1;
    cycle(); fetch_req = 1'b0;
    check("to_rd_en", mem_rd_en, 1);
    n = 0;
    do begin cycle(); n++; end while (!fetch_done && n < 40);
    check("to_latency", n, T + 2);
    check("to_mdr", mdr, 8'h00);
    check("to_err", bus_err, 1);
    fetch_req = 1'b1;
    cycle(); fetch_req = 1'b0;
    cycle(); mem_rd_valid = 1'b1; mem_rd_data = 8'h11;
    cycle(); mem_rd_valid = 1'b0;
    check("to_ok_mdr", mdr, 8'h11);
    check("to_err_sticky", bus_err, 1);

    // Boundary: valid exactly when the counter reaches TIMEOUT; pc_inc mid-read
    rst_n = 1'b0;
    cycle(); cycle(); rst_n = 1'b1;
    check("bd_err_clr", bus_err, 0);
    pc_load = 1'b1; pc_load_val = 16'h0200;
    cycle(); pc_load = 1'b0; fetch_req = 1'b1;
    cycle(); fetch_req = 1'b0; pc_inc = 1'b1;
    cycle(); pc_inc = 1'b0;
    repeat (15) cycle();
    check("bd_addr_held", mem_addr, 16'h0200);
    check("bd_pc", pc, 16'h0201);
    mem_rd_valid = 1'b1; mem_rd_data = 8'h3C;
    cycle(); mem_rd_valid = 1'b0;
    check("bd_done", fetch_done, 1);
    check("bd_mdr", mdr, 8'h3C);
    check("bd_err", bus_err, 0);

    // Reset mid-WAIT
    pc_load = 1'b1; pc_load_val = 16'h0042;
    cycle(); pc_load = 1'b0; fetch_req = 1'b1;
    cycle(); fetch_req = 1'b0;
    cycle();
    check("mr_busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_pc", pc, 16'h0000);
    check("mr_busy", busy, 0);
    check("mr_rd_en", mem_rd_en, 0);
    cycle(); rst_n = 1'b1; mem_rd_valid = 1'b1; mem_rd_data = 8'h77;
    cycle(); mem_rd_valid = 1'b0;
    cycle();
    check("mr_mdr", mdr, 8'h00);
    check("mr_done", fetch_done, 0);
    check("mr_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
